// File: rtl/bus_pkg.sv
// Shared definitions for the data bus arbiter: write-enable encoding,
// arbitration state encoding and read-owner encoding.
package bus_pkg;

    localparam logic [3:0] WE_READ = 4'b0000;

    typedef enum logic {
        ARB_S   = 1'b0,
        LOCK1_S = 1'b1
    } arb_state_t;

    localparam logic OWN_M0 = 1'b0;
    localparam logic OWN_M1 = 1'b1;

endpackage

// File: rtl/bus_rd_router.sv
// Remembers which master issued the read accepted last cycle and steers the
// returning bus_rdata and a one-cycle rvalid pulse to that master only.
module bus_rd_router
    import bus_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_accept,
    input  logic        rd_master,
    input  logic [31:0] bus_rdata,
    output logic [31:0] m0_rdata,
    output logic        m0_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_rvalid
);

    logic rd_pend;
    logic rd_owner;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend  <= 1'b0;
            rd_owner <= OWN_M0;
        end else begin
            rd_pend <= rd_accept;
            if (rd_accept) begin
                rd_owner <= rd_master;
            end
        end
    end

    assign m0_rvalid = rd_pend && (rd_owner == OWN_M0);
    assign m1_rvalid = rd_pend && (rd_owner == OWN_M1);
    assign m0_rdata  = m0_rvalid ? bus_rdata : 32'h0;
    assign m1_rdata  = m1_rvalid ? bus_rdata : 32'h0;

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master data bus arbiter: m0 (core) has priority, m1 gets a forced grant
// after STARVE_LIMIT denied cycles and may lock the bus for up to MAX_LOCK accepts.
module data_bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned MAX_LOCK     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic [3:0]  m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    output logic        m0_rvalid,
    input  logic        m1_req,
    input  logic [3:0]  m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        m1_rvalid,
    input  logic        m1_lock,
    output logic        bus_re,
    output logic [3:0]  bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    output arb_state_t  dbg_state
);

    // Handshake: a master holds req/we/addr/wdata stable until ready is seen;
    // an access is accepted in the cycle where req && ready, and ready is
    // combinational from the current req so the winner sees zero latency.

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [3:0] LOCK_MAX   = 4'(MAX_LOCK);

    arb_state_t  state, state_nxt;
    logic [3:0]  starve_cnt, starve_nxt;
    logic [3:0]  lock_cnt, lock_nxt;
    logic        grant_m0, grant_m1;
    logic        accept;
    logic [3:0]  sel_we;
    logic [31:0] sel_addr, sel_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB_S;
            starve_cnt <= 4'd0;
            lock_cnt   <= 4'd0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            lock_cnt   <= lock_nxt;
        end
    end

    always_comb begin
        grant_m0   = 1'b0;
        grant_m1   = 1'b0;
        state_nxt  = state;
        starve_nxt = starve_cnt;
        lock_nxt   = lock_cnt;

        // Grants are forced low during reset so no access leaks onto the bus.
        if (!rst) begin
            if (state == LOCK1_S) begin
                grant_m1 = m1_req;
            end else begin
                grant_m1 = m1_req && (!m0_req || starve_cnt == STARVE_MAX);
                grant_m0 = m0_req && !grant_m1;
            end
        end

        if (grant_m1) begin
            starve_nxt = 4'd0;
        end else if (m1_req && starve_cnt != STARVE_MAX) begin
            starve_nxt = starve_cnt + 4'd1;
        end

        case (state)
            ARB_S: begin
                lock_nxt = 4'd0;
                // A single-access lock budget is used up by the entry accept itself.
                if (grant_m1 && m1_lock && LOCK_MAX != 4'd1) begin
                    state_nxt = LOCK1_S;
                    lock_nxt  = 4'd1;
                end
            end
            LOCK1_S: begin
                if (!m1_req || !m1_lock || (lock_cnt + 4'd1) == LOCK_MAX) begin
                    state_nxt = ARB_S;
                    lock_nxt  = 4'd0;
                end else begin
                    lock_nxt = lock_cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = ARB_S;
                lock_nxt  = 4'd0;
            end
        endcase
    end

    assign m0_ready  = grant_m0;
    assign m1_ready  = grant_m1;
    assign accept    = grant_m0 || grant_m1;
    assign dbg_state = state;

    assign sel_we    = grant_m1 ? m1_we    : m0_we;
    assign sel_addr  = grant_m1 ? m1_addr  : m0_addr;
    assign sel_wdata = grant_m1 ? m1_wdata : m0_wdata;

    assign bus_re    = accept && (sel_we == WE_READ);
    assign bus_we    = accept ? sel_we    : WE_READ;
    assign bus_addr  = accept ? sel_addr  : 32'h0;
    assign bus_wdata = accept ? sel_wdata : 32'h0;

    bus_rd_router u_rd_router (
        .clk       (clk),
        .rst       (rst),
        .rd_accept (bus_re),
        .rd_master (grant_m1 ? OWN_M1 : OWN_M0),
        .bus_rdata (bus_rdata),
        .m0_rdata  (m0_rdata),
        .m0_rvalid (m0_rvalid),
        .m1_rdata  (m1_rdata),
        .m1_rvalid (m1_rvalid)
    );

endmodule
